mc_proc: RTL and testbench



---
 rtl/mc_proc_pkg.sv | 66 ++++++
 rtl/mc_proc_alu.sv | 49 ++++
 rtl/mc_proc.sv | 252 +++++++++++++++++++++++++
 tb/tb_mc_proc.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_proc_pkg.sv
// mc_proc_pkg: shared types and helpers for the mc_proc processor.
//   - opcode_e     : instruction opcodes (4-bit field at the top of the word)
//   - state_e      : main FSM states
//   - ST_* indices : bit positions inside the status register
//   - f_* helpers  : instruction field extraction for any WIDTH up to MAX_W
// Optional feature macro used by the processor: MC_PROC_MUL_EN.
package mc_proc_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [3:0] {
      OP_HLT = 4'd0,
      OP_BRA = 4'd1,
      OP_NOP = 4'd2,
      OP_STR = 4'd3,
      OP_SHF = 4'd4,
      OP_CPL = 4'd5,
      OP_ADD = 4'd6,
      OP_MUL = 4'd7,
      OP_LDI = 4'd8,
      OP_LDM = 4'd9
   } opcode_e;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_FWAIT = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MWAIT = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   // Status register layout. ALWAYS is constant 1 so BRA cc=0 is an
   // unconditional jump.
   localparam int ST_ALWAYS = 0;
   localparam int ST_CARRY  = 1;
   localparam int ST_EVEN   = 2;
   localparam int ST_PARITY = 3;
   localparam int ST_ZERO   = 4;
   localparam int ST_NEG    = 5;

   // Fields are top-aligned, so the instruction is passed zero-extended to
   // MAX_W together with its real width w.
   function automatic logic [3:0] f_op(input logic [MAX_W-1:0] ir, input int w);
      f_op = ir[w-1 -: 4];
   endfunction

   function automatic logic [3:0] f_cc(input logic [MAX_W-1:0] ir, input int w);
      f_cc = ir[w-5 -: 4];
   endfunction

   function automatic logic [3:0] f_ra(input logic [MAX_W-1:0] ir, input int w);
      f_ra = ir[w-9 -: 4];
   endfunction

   function automatic logic [3:0] f_rb(input logic [MAX_W-1:0] ir, input int w);
      f_rb = ir[w-13 -: 4];
   endfunction

   // Immediate is everything below the rb field: ir[w-17:0].
   function automatic logic [MAX_W-1:0] f_imm(input logic [MAX_W-1:0] ir, input int w);
      logic [MAX_W-1:0] mask;
      mask  = (MAX_W'(1) << (w - 16)) - MAX_W'(1);
      f_imm = ir & mask;
   endfunction

endpackage

// File: rtl/mc_proc_alu.sv
// mc_proc_alu: combinational datapath for the flag-setting instructions.
// Ports:
//   op     in  4        opcode (SHF, CPL, ADD, MUL; anything else yields 0)
//   a      in  WIDTH    first operand (R[ra])
//   b      in  WIDTH    second operand (R[rb] or zero-extended immediate)
//   shamt  in  5        shift amount for SHF
//   shl    in  1        1 = shift left, 0 = shift right (logical)
//   res    out WIDTH+1  result; bit WIDTH is the carry (ADD only)
//   flags  out SBITS    status vector derived from res
// MC_PROC_MUL_EN: when undefined no multiplier is built and MUL yields 0.
module mc_proc_alu
   import mc_proc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SBITS = 6
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   input  logic             shl,
   output logic [WIDTH:0]   res,
   output logic [SBITS-1:0] flags
);

   always_comb begin
      res = '0;
      case (op)
         OP_SHF:  res = {1'b0, (shl ? (a << shamt) : (a >> shamt))};
         OP_CPL:  res = {1'b0, ~b};
         OP_ADD:  res = {1'b0, a} + {1'b0, b};
`ifdef MC_PROC_MUL_EN
         OP_MUL:  res = {1'b0, WIDTH'(a * b)};
`endif
         default: res = '0;
      endcase
   end

   always_comb begin
      flags            = '0;
      flags[ST_ALWAYS] = 1'b1;
      flags[ST_CARRY]  = res[WIDTH];
      flags[ST_EVEN]   = ~res[0];
      flags[ST_PARITY] = ^res[WIDTH-1:0];
      flags[ST_ZERO]   = (res[WIDTH-1:0] == '0);
      flags[ST_NEG]    = res[WIDTH-1];
   end

endmodule

// File: rtl/mc_proc.sv
// mc_proc: multi-cycle accumulator-style processor (fetch / decode / execute)
// on a single req/ack memory bus shared by instructions and data.
// Ports:
//   clk, nrst   clock; asynchronous active-low reset
//   mem_req     bus request, held until mem_ack is sampled
//   mem_we      1 = write, 0 = read (valid while mem_req)
//   mem_addr    bus address
//   mem_wdata   write data
//   mem_rdata   read data, valid in the cycle mem_ack=1
//   mem_ack     transfer complete; ignored while mem_req=0
//   halted      core is in HALT
//   illegal_op  one-cycle pulse in EXEC for an undecodable instruction
//   pc          program counter
//   status      status register (ALWAYS, CARRY, EVEN, PARITY, ZERO, NEG)
// Handshake: a request is registered; its fields stay constant until the
// cycle mem_ack is sampled high, and mem_req drops on the following edge.
// Optional feature macro: MC_PROC_MUL_EN (single-cycle MUL). When undefined
// opcode 7 is reported as illegal.
module mc_proc
   import mc_proc_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 8,
   parameter int NREGS  = 8,
   parameter int SBITS  = 6
) (
   input  logic              clk,
   input  logic              nrst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic              illegal_op,
   output logic [ADDR_W-1:0] pc,
   output logic [SBITS-1:0]  status
);

   localparam int IMM_W = WIDTH - 16;
   localparam int RI_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int SI_W  = $clog2(SBITS);
   localparam logic [4:0] NREGS_L = 5'(NREGS);
   localparam logic [4:0] SBITS_L = 5'(SBITS);

`ifdef MC_PROC_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [WIDTH-1:0]  ir_q, ir_d;
   logic [SBITS-1:0]  status_q, status_d;
   logic [WIDTH-1:0]  regs_q [NREGS];
   logic [WIDTH-1:0]  regs_d [NREGS];
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_FETCH;
         pc_q        <= '0;
         ir_q        <= '0;
         status_q    <= SBITS'(1);
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         status_q    <= status_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         regs_q      <= regs_d;
      end
   end

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [3:0]        op, cc, ra, rb;
   logic [IMM_W-1:0]  imm;
   logic [WIDTH-1:0]  imm_ext;
   logic [ADDR_W-1:0] addr;
   logic              imm_flag;
   logic              ra_ok, rb_ok, uses_ra, uses_rb;
   logic              illegal;
   logic [RI_W-1:0]   ra_idx, rb_idx;
   logic [SI_W-1:0]   cc_idx;
   logic [WIDTH-1:0]  op_a, op_b;

   always_comb begin
      op       = f_op(MAX_W'(ir_q), WIDTH);
      cc       = f_cc(MAX_W'(ir_q), WIDTH);
      ra       = f_ra(MAX_W'(ir_q), WIDTH);
      rb       = f_rb(MAX_W'(ir_q), WIDTH);
      imm      = IMM_W'(f_imm(MAX_W'(ir_q), WIDTH));
      imm_ext  = {16'b0, imm};
      addr     = imm[ADDR_W-1:0];
      imm_flag = cc[3];
      cc_idx   = cc[SI_W-1:0];

      ra_ok = ({1'b0, ra} < NREGS_L);
      rb_ok = ({1'b0, rb} < NREGS_L);

      // Register fields are only validated for instructions that use them,
      // so unused fields may hold arbitrary bits.
      uses_ra = (op == OP_STR) || (op == OP_SHF) || (op == OP_CPL) ||
                (op == OP_ADD) || (op == OP_MUL) || (op == OP_LDI) ||
                (op == OP_LDM);
      uses_rb = (op == OP_MUL) ||
                (((op == OP_ADD) || (op == OP_CPL)) && !imm_flag);

      illegal = (op > 4'd9) ||
                ((op == OP_MUL) && !MUL_EN) ||
                ((op == OP_BRA) && ({1'b0, cc} >= SBITS_L)) ||
                (uses_ra && !ra_ok) ||
                (uses_rb && !rb_ok);

      // Out-of-range indices are clamped; such instructions are illegal
      // and never commit anything.
      ra_idx = ra_ok ? ra[RI_W-1:0] : '0;
      rb_idx = rb_ok ? rb[RI_W-1:0] : '0;

      op_a = regs_q[ra_idx];
      op_b = (((op == OP_ADD) || (op == OP_CPL)) && imm_flag) ? imm_ext
                                                              : regs_q[rb_idx];
   end

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   logic [WIDTH:0]   alu_res;
   logic [SBITS-1:0] alu_flags;

   mc_proc_alu #(
      .WIDTH (WIDTH),
      .SBITS (SBITS)
   ) u_alu (
      .op    (op),
      .a     (op_a),
      .b     (op_b),
      .shamt (imm[4:0]),
      .shl   (cc[0]),
      .res   (alu_res),
      .flags (alu_flags)
   );

   // ------------------------------------------------------------------
   // FSM next-state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      status_d    = status_q;
      regs_d      = regs_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ST_FETCH: begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
            state_d    = ST_FWAIT;
         end

         ST_FWAIT: begin
            if (mem_ack) begin
               ir_d      = mem_rdata;
               pc_d      = pc_q + 1'b1;
               mem_req_d = 1'b0;
               state_d   = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d = ST_FETCH;
            if (!illegal) begin
               case (op)
                  OP_HLT: state_d = ST_HALT;
                  OP_BRA: begin
                     if (status_q[cc_idx]) pc_d = addr;
                  end
                  OP_STR: begin
                     mem_req_d   = 1'b1;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = addr;
                     mem_wdata_d = op_a;
                     state_d     = ST_MWAIT;
                  end
                  OP_LDM: begin
                     mem_req_d  = 1'b1;
                     mem_we_d   = 1'b0;
                     mem_addr_d = addr;
                     state_d    = ST_MWAIT;
                  end
                  OP_SHF, OP_CPL, OP_ADD, OP_MUL: begin
                     regs_d[ra_idx] = alu_res[WIDTH-1:0];
                     status_d       = alu_flags;
                  end
                  OP_LDI: regs_d[ra_idx] = imm_ext;
                  default: ;
               endcase
            end
         end

         ST_MWAIT: begin
            if (mem_ack) begin
               if (!mem_we_q) regs_d[ra_idx] = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = ST_FETCH;
            end
         end

         ST_HALT: state_d = ST_HALT;

         default: state_d = ST_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign halted     = (state_q == ST_HALT);
   assign illegal_op = (state_q == ST_EXEC) && illegal;
   assign pc         = pc_q;
   assign status     = status_q;

endmodule

// File: tb/tb_mc_proc.sv
// tb_mc_proc: directed programs for mc_proc with a memory model and a
// transaction scoreboard. Expected bus transfers are queued as
// {we, addr, wdata}; a monitor pops one entry per completed transfer.
module tb_mc_proc;

   localparam int W     = 32;
   localparam int AW    = 8;
   localparam int NR    = 8;
   localparam int SB    = 6;
   localparam int TXN_W = 1 + AW + W;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          halted, illegal_op;
   logic [AW-1:0] pc;
   logic [SB-1:0] status;

   mc_proc #(
      .WIDTH (W),
      .ADDR_W(AW),
      .NREGS (NR),
      .SBITS (SB)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .halted    (halted),
      .illegal_op(illegal_op),
      .pc        (pc),
      .status    (status)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;
   int illegal_cnt = 0;
   logic [TXN_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] enc(input logic [3:0] op, input logic [3:0] cc,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [15:0] imm);
      enc = {op, cc, ra, rb, imm};
   endfunction

   task automatic push_rd(input logic [AW-1:0] a);
      exp_q.push_back({1'b0, a, {W{1'b0}}});
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      exp_q.push_back({1'b1, a, d});
   endtask

   // ---------------- memory model ----------------
   logic [W-1:0]  mem [256];
   int            rd_delay = 0;
   int            wr_delay = 0;
   int            wait_cnt = 0;
   logic          pend = 1'b0;
   logic [AW-1:0] cap_addr = '0;
   logic          cap_we = 1'b0;

   always @(negedge clk) begin
      if (!mem_req) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
         pend     = 1'b0;
      end else if (!mem_ack) begin
         if (pend) begin
            chk("req_addr_stable", 64'(mem_addr), 64'(cap_addr));
            chk("req_we_stable", 64'(mem_we), 64'(cap_we));
         end else begin
            pend     = 1'b1;
            cap_addr = mem_addr;
            cap_we   = mem_we;
         end
         if (wait_cnt >= (mem_we ? wr_delay : rd_delay)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
         end else begin
            wait_cnt++;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [TXN_W-1:0] exp_t;

   always begin
      @(negedge clk);
      #1;
      if (mem_req && mem_ack) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_txn: actual we=%0b addr=%0h required none", mem_we, mem_addr);
         end else begin
            exp_t = exp_q.pop_front();
            chk("txn_we", 64'(mem_we), 64'(exp_t[TXN_W-1]));
            chk("txn_addr", 64'(mem_addr), 64'(exp_t[W +: AW]));
            if (exp_t[TXN_W-1]) chk("txn_wdata", 64'(mem_wdata), 64'(exp_t[W-1:0]));
         end
      end
      if (illegal_op) illegal_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic apply_reset();
      step();
      nrst = 1'b0;
      step();
      step();
      exp_q.delete();
      illegal_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic finish_prog(input string name, input logic [SB-1:0] exp_status);
      int   n;
      logic saw_req;
      n = 0;
      while (!halted && n < 300) begin
         step();
         n++;
      end
      chk({name, "_halted"}, 64'(halted), 64'd1);
      chk({name, "_status"}, 64'(status), 64'(exp_status));
      step();
      chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
      saw_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (mem_req) saw_req = 1'b1;
      end
      chk({name, "_no_req_after_halt"}, 64'(saw_req), 64'd0);
   endtask

   task automatic load_p1();
      mem[0] = enc(4'd8, 4'd0, 4'd1, 4'd0, 16'd5);   // LDI R1,5
      mem[1] = enc(4'd8, 4'd0, 4'd2, 4'd0, 16'd7);   // LDI R2,7
      mem[2] = enc(4'd6, 4'd0, 4'd1, 4'd2, 16'd0);   // ADD R1,R2
      mem[3] = enc(4'd3, 4'd0, 4'd1, 4'd0, 16'h40);  // STR R1,0x40
      mem[4] = enc(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);   // HLT
      push_rd(8'h00);
      push_rd(8'h01);
      push_rd(8'h02);
      push_rd(8'h03);
      push_wr(8'h40, 32'd12);
      push_rd(8'h04);
   endtask

   // ---------------- stimulus ----------------
   int n;

   initial begin
      repeat (3) @(negedge clk);
      #2;

      // Reset state
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_illegal_op", 64'(illegal_op), 64'd0);
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_status", 64'(status), 64'd1);

      // Program 1, single-cycle ack
      apply_reset();
      rd_delay = 0;
      wr_delay = 0;
      load_p1();
      nrst = 1'b1;
      n = 0;
      while (!(mem_req && mem_ack) && n < 20) begin
         step();
         n++;
      end
      step();
      chk("pc_after_first_fetch", 64'(pc), 64'd1);
      finish_prog("p1_ack1", 6'b000101);

      // Program 1, three-cycle ack delay
      apply_reset();
      rd_delay = 3;
      wr_delay = 3;
      load_p1();
      nrst = 1'b1;
      finish_prog("p1_ack3", 6'b000101);

      // Carry/zero from ADD immediate, branches on NEG (not taken) and ZERO
      apply_reset();
      rd_delay = 0;
      wr_delay = 0;
      mem[8'h00] = enc(4'd9, 4'd0, 4'd0, 4'd0, 16'h50);    // LDM R0,0x50
      mem[8'h50] = 32'hFFFF_FFFF;
      mem[8'h01] = enc(4'd6, 4'b1000, 4'd0, 4'd0, 16'd1);  // ADD R0,#1
      mem[8'h02] = enc(4'd1, 4'd5, 4'd0, 4'd0, 16'h30);    // BRA NEG,0x30
      mem[8'h03] = enc(4'd1, 4'd4, 4'd0, 4'd0, 16'h20);    // BRA ZERO,0x20
      mem[8'h20] = enc(4'd3, 4'd0, 4'd0, 4'd0, 16'h41);    // STR R0,0x41
      mem[8'h21] = enc(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);     // HLT
      push_rd(8'h00);
      push_rd(8'h50);
      push_rd(8'h01);
      push_rd(8'h02);
      push_rd(8'h03);
      push_rd(8'h20);
      push_wr(8'h41, 32'd0);
      push_rd(8'h21);
      nrst = 1'b1;
      finish_prog("carry_branch", 6'b010111);

      // Illegal encodings and MUL
      apply_reset();
      mem[0] = enc(4'd8, 4'd0, 4'd3, 4'd0, 16'h1234);  // LDI R3,0x1234
      mem[1] = 32'hC000_0000;                         // opcode 0xC
      mem[2] = enc(4'd8, 4'd0, 4'd9, 4'd0, 16'h5555);  // LDI R9 (ra out of range)
      mem[3] = enc(4'd6, 4'd0, 4'd3, 4'd9, 16'd0);     // ADD R3,R9 (rb out of range)
      mem[4] = enc(4'd7, 4'd0, 4'd3, 4'd3, 16'd0);     // MUL R3,R3
      mem[5] = enc(4'd3, 4'd0, 4'd3, 4'd0, 16'h42);    // STR R3,0x42
      mem[6] = enc(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);     // HLT
      for (int i = 0; i < 6; i++) push_rd(AW'(i));
`ifdef MC_PROC_MUL_EN
      push_wr(8'h42, 32'h014B_5A90);
`else
      push_wr(8'h42, 32'h0000_1234);
`endif
      push_rd(8'h06);
      nrst = 1'b1;
`ifdef MC_PROC_MUL_EN
      finish_prog("illegal", 6'b001101);
      chk("illegal_pulse_count", 64'(illegal_cnt), 64'd3);
`else
      finish_prog("illegal", 6'b000001);
      chk("illegal_pulse_count", 64'(illegal_cnt), 64'd4);
`endif

      // Reset asserted while a write waits in MWAIT
      apply_reset();
      rd_delay = 0;
      wr_delay = 50;
      mem[0] = enc(4'd3, 4'd0, 4'd0, 4'd0, 16'h40);    // STR R0,0x40
      mem[1] = enc(4'd0, 4'd0, 4'd0, 4'd0, 16'd0);     // HLT
      push_rd(8'h00);
      nrst = 1'b1;
      n = 0;
      while (!(mem_req && mem_we) && n < 30) begin
         step();
         n++;
      end
      chk("reached_mwait_write", 64'(mem_req && mem_we), 64'd1);
      #1;
      nrst = 1'b0;
      #1;
      chk("async_rst_req_drop", 64'(mem_req), 64'd0);
      chk("async_rst_we", 64'(mem_we), 64'd0);
      chk("async_rst_pc", 64'(pc), 64'd0);
      step();
      step();
      wr_delay = 0;
      exp_q.delete();
      push_rd(8'h00);
      push_wr(8'h40, 32'd0);
      push_rd(8'h01);
      nrst = 1'b1;
      finish_prog("after_mid_reset", 6'b000001);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
